// File: rtl/mdio_pkg.sv
// Shared types and constants for the clause-22 MDIO peripheral.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        WRITE,
        READ,
        SKIP
    } state_t;

    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam logic [4:0] HDR_LAST   = 5'd13;
    localparam logic [4:0] TA_LAST    = 5'd15;
    localparam logic [4:0] FRAME_LAST = 5'd31;

endpackage

// File: rtl/mdio_peripheral_if.sv
// MDIO serial lines plus register-file port of the peripheral.
interface mdio_peripheral_if;

    logic        MDC;
    logic        MDIO_OE;
    logic        MDIO_OUT;
    logic        MDIO_IN;
    logic        MDIO_IN_EN;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic [15:0] RD_DATA;
    logic        MDIO_DONE;

    modport master (
        output MDC, MDIO_OE, MDIO_OUT, RD_DATA,
        input  MDIO_IN, MDIO_IN_EN, ADDR, WR_DATA, WR_STB, MDIO_DONE
    );

    modport slave (
        input  MDC, MDIO_OE, MDIO_OUT, RD_DATA,
        output MDIO_IN, MDIO_IN_EN, ADDR, WR_DATA, WR_STB, MDIO_DONE
    );

endinterface

// File: rtl/mdc_edge_det.sv
// Registers MDC in the clk domain and flags its rising/falling edges.
module mdc_edge_det (
    input  logic clk,
    input  logic mdc,
    output logic rise,
    output logic fall
);

    logic mdc_q;

    // Left unreset so a reset with MDC high does not fake a rise.
    always_ff @(posedge clk) begin
        mdc_q <= mdc;
    end

    assign rise = mdc & ~mdc_q;
    assign fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_peripheral.sv
// Clause-22 MDIO target: decodes frames into register writes and serves reads.
module mdio_peripheral
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd1
) (
    input logic               clk,
    input logic               rst,
    mdio_peripheral_if.slave  bus
);

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [14:0] sh, sh_n;
    logic [4:0]  addr, addr_n;
    logic [15:0] wdata, wdata_n;
    logic        stb, stb_n;
    logic        done, done_n;
    logic        mdio_in_q, mdio_in_n;
    logic        mdio_en_q, mdio_en_n;
    logic        rise, fall;
    logic        mdo, oe;
    logic [13:0] hdr;

    mdc_edge_det u_edge (
        .clk  (clk),
        .mdc  (bus.MDC),
        .rise (rise),
        .fall (fall)
    );

    assign mdo = bus.MDIO_OUT;
    assign oe  = bus.MDIO_OE;
    // Header as it stands once the bit on this rise is shifted in.
    assign hdr = {sh[12:0], mdo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            addr      <= '0;
            wdata     <= '0;
            stb       <= 1'b0;
            done      <= 1'b0;
            mdio_in_q <= 1'b0;
            mdio_en_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            addr      <= addr_n;
            wdata     <= wdata_n;
            stb       <= stb_n;
            done      <= done_n;
            mdio_in_q <= mdio_in_n;
            mdio_en_q <= mdio_en_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        addr_n    = addr;
        wdata_n   = wdata;
        stb_n     = 1'b0;
        done_n    = 1'b0;
        mdio_in_n = mdio_in_q;
        mdio_en_n = mdio_en_q;
        unique case (state)
            IDLE: begin
                if (rise && oe) begin
                    sh_n    = {sh[13:0], mdo};
                    cnt_n   = 5'd1;
                    state_n = HEADER;
                end
            end
            HEADER: begin
                if (rise) begin
                    if (!oe) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        sh_n  = {sh[13:0], mdo};
                        cnt_n = cnt + 5'd1;
                        if (cnt == HDR_LAST) begin
                            if (hdr[13:12] != ST_START || hdr[9:5] != PHY_ADDR) begin
                                state_n = SKIP;
                            end else if (hdr[11:10] == OP_WRITE) begin
                                state_n = WRITE;
                                addr_n  = hdr[4:0];
                            end else if (hdr[11:10] == OP_READ) begin
                                state_n = READ;
                                addr_n  = hdr[4:0];
                            end else begin
                                state_n = SKIP;
                            end
                        end
                    end
                end
            end
            WRITE: begin
                if (rise) begin
                    if (cnt > TA_LAST && !oe) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        sh_n  = {sh[13:0], mdo};
                        cnt_n = cnt + 5'd1;
                        if (cnt == FRAME_LAST) begin
                            wdata_n = {sh, mdo};
                            stb_n   = 1'b1;
                            done_n  = 1'b1;
                            state_n = IDLE;
                            cnt_n   = '0;
                        end
                    end
                end
            end
            READ: begin
                if (rise) begin
                    cnt_n = cnt + 5'd1;
                    if (cnt == FRAME_LAST) begin
                        mdio_en_n = 1'b0;
                        mdio_in_n = 1'b0;
                        done_n    = 1'b1;
                        state_n   = IDLE;
                        cnt_n     = '0;
                    end
                end else if (fall) begin
                    // cnt already points at the bit the controller samples next.
                    if (cnt == TA_LAST) begin
                        mdio_en_n = 1'b1;
                        mdio_in_n = 1'b0;
                    end else if (cnt == TA_LAST + 5'd1) begin
                        sh_n      = bus.RD_DATA[14:0];
                        mdio_in_n = bus.RD_DATA[15];
                    end else if (cnt > TA_LAST + 5'd1) begin
                        mdio_in_n = sh[14];
                        sh_n      = {sh[13:0], 1'b0};
                    end
                end
            end
            SKIP: begin
                if (rise) begin
                    cnt_n = cnt + 5'd1;
                    if (cnt == FRAME_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.MDIO_IN    = mdio_in_q;
    assign bus.MDIO_IN_EN = mdio_en_q;
    assign bus.ADDR       = addr;
    assign bus.WR_DATA    = wdata;
    assign bus.WR_STB     = stb;
    assign bus.MDIO_DONE  = done;

endmodule

// File: tb/tb_mdio_peripheral.sv
// Randomized frame-level bench for mdio_peripheral against a frame model.
module tb_mdio_peripheral;

    localparam logic [4:0] PHY = 5'd1;

    typedef struct packed {
        logic [3:0]  stb;
        logic [3:0]  done;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [31:0] din;
        logic [31:0] den;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mdio_peripheral_if bus ();

    mdio_peripheral #(.PHY_ADDR(PHY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] regs [32];
    assign bus.RD_DATA = regs[bus.ADDR];

    int compared   = 0;
    int mismatched = 0;

    int          stb_cnt  = 0;
    int          done_cnt = 0;
    int          stb_solo = 0;
    int          bad_in   = 0;
    logic [4:0]  cap_addr = '0;
    logic [15:0] cap_data = '0;

    always @(negedge clk) begin
        if (bus.WR_STB) begin
            stb_cnt++;
            cap_addr = bus.ADDR;
            cap_data = bus.WR_DATA;
            if (!bus.MDIO_DONE) stb_solo++;
        end
        if (bus.MDIO_DONE) done_cnt++;
        if (!bus.MDIO_IN_EN && bus.MDIO_IN) bad_in++;
    end

    // Expected outcome of one frame, from the frame fields alone.
    function automatic res_t model(input logic [31:0] w, input int oe_last);
        res_t        e;
        logic [1:0]  st, op;
        logic [4:0]  phy, rg;
        logic [15:0] d;
        bit          ok;
        e   = '0;
        st  = w[31:30];
        op  = w[29:28];
        phy = w[27:23];
        rg  = w[22:18];
        ok  = (st == 2'b01) && (phy == PHY);
        if (ok && op == 2'b01 && oe_last >= 31) begin
            e.stb   = 4'd1;
            e.done  = 4'd1;
            e.addr  = rg;
            e.wdata = w[15:0];
        end
        if (ok && op == 2'b10 && oe_last >= 13) begin
            e.done = 4'd1;
            d      = regs[rg];
            e.den  = 32'hFFFF_8000;
            for (int k = 0; k < 16; k++) e.din[16+k] = d[15-k];
        end
        return e;
    endfunction

    // Controller side: bit n is set up while MDC is low and sampled on its rise.
    task automatic do_frame(input logic [31:0] w, input int oe_last,
                            input int nbits, output res_t r);
        int s0, d0;
        r        = '0;
        s0       = stb_cnt;
        d0       = done_cnt;
        cap_addr = '0;
        cap_data = '0;
        for (int n = 0; n < nbits; n++) begin
            bus.MDC      = 1'b0;
            bus.MDIO_OE  = (n <= oe_last);
            bus.MDIO_OUT = (n <= oe_last) ? w[31-n] : 1'b0;
            repeat (4) @(negedge clk);
            bus.MDC    = 1'b1;
            r.din[n]   = bus.MDIO_IN;
            r.den[n]   = bus.MDIO_IN_EN;
            repeat (4) @(negedge clk);
        end
        bus.MDIO_OE  = 1'b0;
        bus.MDIO_OUT = 1'b0;
        repeat (6) @(negedge clk);
        r.stb   = 4'(stb_cnt - s0);
        r.done  = 4'(done_cnt - d0);
        r.addr  = cap_addr;
        r.wdata = cap_data;
    endtask

    task automatic report(input string tag, input res_t o, input res_t e);
        $display("FAIL %s: got stb=%0d done=%0d addr=%0d wd=%h din=%h den=%h want stb=%0d done=%0d addr=%0d wd=%h din=%h den=%h",
                 tag, o.stb, o.done, o.addr, o.wdata, o.din, o.den,
                 e.stb, e.done, e.addr, e.wdata, e.din, e.den);
    endtask

    task automatic test_reset;
        logic [24:0] outs;
        bus.MDC = 1'b0; bus.MDIO_OE = 1'b0; bus.MDIO_OUT = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        outs = {bus.MDIO_IN, bus.MDIO_IN_EN, bus.ADDR, bus.WR_DATA, bus.WR_STB, bus.MDIO_DONE};
        compared++;
        if (outs !== '0) begin
            mismatched++;
            $display("FAIL reset_hold: outputs=%h want 0", outs);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.MDIO_IN, bus.MDIO_IN_EN, bus.ADDR, bus.WR_DATA, bus.WR_STB, bus.MDIO_DONE};
        compared++;
        if (outs !== '0) begin
            mismatched++;
            $display("FAIL reset_release: outputs=%h want 0", outs);
        end
    endtask

    task automatic test_write;
        res_t o, e;
        int   solo0;
        solo0 = stb_solo;
        do_frame(32'h5096_BEEF, 31, 32, o);
        e = model(32'h5096_BEEF, 31);
        compared++;
        if (o !== e) begin mismatched++; report("write_beef", o, e); end
        compared++;
        if (stb_solo != solo0) begin
            mismatched++;
            $display("FAIL write_done_align: stb without done=%0d want 0", stb_solo - solo0);
        end
        compared++;
        if (bus.WR_DATA !== 16'hBEEF || bus.ADDR !== 5'd5) begin
            mismatched++;
            $display("FAIL write_hold: addr=%0d wd=%h want 5 beef", bus.ADDR, bus.WR_DATA);
        end
    endtask

    task automatic test_read;
        res_t o, e;
        do_frame(32'h6096_0000, 13, 32, o);
        e = model(32'h6096_0000, 13);
        compared++;
        if (o !== e) begin mismatched++; report("read_a5c3", o, e); end
        compared++;
        if (bus.ADDR !== 5'd5 || bus.MDIO_IN_EN !== 1'b0 || bus.MDIO_IN !== 1'b0) begin
            mismatched++;
            $display("FAIL read_after: addr=%0d en=%b in=%b want 5 0 0",
                     bus.ADDR, bus.MDIO_IN_EN, bus.MDIO_IN);
        end
    endtask

    task automatic test_addr_mismatch;
        res_t o, e;
        do_frame(32'h5116_BEEF, 31, 32, o);
        e = model(32'h5116_BEEF, 31);
        compared++;
        if (o !== e) begin mismatched++; report("phy_mismatch", o, e); end
        do_frame(32'h5096_1234, 31, 32, o);
        e = model(32'h5096_1234, 31);
        compared++;
        if (o !== e) begin mismatched++; report("phy_followup", o, e); end
    endtask

    task automatic test_bad_st_op;
        res_t o, e;
        do_frame(32'h8A5A_FF01, 31, 32, o);
        e = model(32'h8A5A_FF01, 31);
        compared++;
        if (o !== e) begin mismatched++; report("bad_st", o, e); end
        do_frame(32'h7096_4321, 31, 32, o);
        e = model(32'h7096_4321, 31);
        compared++;
        if (o !== e) begin mismatched++; report("bad_op", o, e); end
        do_frame(32'h5096_BEEF, 31, 32, o);
        e = model(32'h5096_BEEF, 31);
        compared++;
        if (o !== e) begin mismatched++; report("bad_followup", o, e); end
    endtask

    task automatic test_abort;
        res_t o, e;
        do_frame(32'h509A_CAFE, 20, 32, o);
        e = model(32'h509A_CAFE, 20);
        compared++;
        if (o !== e) begin mismatched++; report("abort_write", o, e); end
        do_frame(32'h509A_CAFE, 31, 32, o);
        e = model(32'h509A_CAFE, 31);
        compared++;
        if (o !== e) begin mismatched++; report("abort_followup", o, e); end
    endtask

    task automatic test_reset_mid_read;
        res_t        o, e;
        logic [24:0] outs;
        do_frame(32'h6096_0000, 13, 25, o);
        e = model(32'h6096_0000, 13);
        compared++;
        if (o.din[24:0] !== e.din[24:0] || o.den[24:0] !== e.den[24:0] ||
            bus.MDIO_IN_EN !== 1'b1 || o.done !== 4'd0) begin
            mismatched++;
            $display("FAIL partial_read: din=%h den=%h en=%b done=%0d want din=%h den=%h en=1 done=0",
                     o.din[24:0], o.den[24:0], bus.MDIO_IN_EN, o.done,
                     e.din[24:0], e.den[24:0]);
        end
        rst = 1'b1;
        @(negedge clk);
        outs = {bus.MDIO_IN, bus.MDIO_IN_EN, bus.ADDR, bus.WR_DATA, bus.WR_STB, bus.MDIO_DONE};
        compared++;
        if (outs !== '0) begin
            mismatched++;
            $display("FAIL mid_read_reset: outputs=%h want 0", outs);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_frame(32'h6096_0000, 13, 32, o);
        compared++;
        if (o !== e) begin mismatched++; report("read_after_reset", o, e); end
    endtask

    task automatic test_random;
        res_t        o, e;
        logic [1:0]  st, op;
        logic [4:0]  phy, rg;
        logic [15:0] d;
        logic [31:0] w;
        int          oe_last;
        for (int i = 0; i < 24; i++) begin
            phy = ($urandom_range(0, 3) == 0) ? 5'd2 : PHY;
            st  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b01;
            op  = 2'($urandom_range(0, 3));
            rg  = 5'($urandom);
            d   = 16'($urandom);
            w   = {st, op, phy, rg, 2'b10, d};
            oe_last = (op == 2'b10) ? 13 : 31;
            if ($urandom_range(0, 4) == 0) oe_last = $urandom_range(0, 30);
            do_frame(w, oe_last, 32, o);
            e = model(w, oe_last);
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL rand%0d w=%h oe_last=%0d", i, w, oe_last);
                report("rand", o, e);
            end
        end
        compared++;
        if (bad_in != 0) begin
            mismatched++;
            $display("FAIL in_without_en: cycles=%0d want 0", bad_in);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 16'($urandom);
        regs[5] = 16'hA5C3;
        test_reset();
        test_write();
        test_read();
        test_addr_mismatch();
        test_bad_st_op();
        test_abort();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
